key_load_ctrl: RTL



---
 rtl/key_load_if.sv | 26 ++
 rtl/key_load_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/key_load_if.sv
// Key-load handshake bundle: control/serial-key inputs, applied key and gated core outputs.
// master drives requests and core_in; slave is the key_load_ctrl side.
interface key_load_if #(
  parameter int KEY_W = 32
);
  logic             start;
  logic             abort;
  logic             key_sdi;
  logic             key_sv;
  logic [6:0]       core_in;
  logic [KEY_W-1:0] keyinput;
  logic [6:0]       core_out;
  logic             key_ready;
  logic             busy;
  logic             err;

  modport master (
    output start, abort, key_sdi, key_sv, core_in,
    input  keyinput, core_out, key_ready, busy, err
  );

  modport slave (
    input  start, abort, key_sdi, key_sv, core_in,
    output keyinput, core_out, key_ready, busy, err
  );
endinterface

// File: rtl/key_load_ctrl.sv
// Serial key loader for a logic-locked core: shifts KEY_W bits MSB first, commits, waits SETTLE_CYC+1 cycles.
// Optional KEY_PARITY_EN adds a trailing even-parity bit checked in CHECK; key_sv=0 simply stalls the shift.
module key_load_ctrl #(
  parameter int KEY_W      = 32,
  parameter int SETTLE_CYC = 4
) (
  input logic       clk,
  input logic       rst_n,
  key_load_if.slave bus
);
  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
`ifdef KEY_PARITY_EN
    CHECK  = 3'd2,
`endif
    SETTLE = 3'd3,
    READY  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       settle_q, settle_d;
  logic             last_bit;

  assign last_bit = bus.key_sv && (bit_cnt_q == CNT_W'(KEY_W - 1));

`ifdef KEY_PARITY_EN
  logic err_q, err_d;
  logic parity_ok;
  // Even parity: key bits plus the parity bit must XOR to zero.
  assign parity_ok = ((^shadow_q) ^ bus.key_sdi) == 1'b0;
`else
  logic shadow_msb_unused;
  assign shadow_msb_unused = shadow_q[KEY_W-1];
`endif

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    key_d     = key_q;
    bit_cnt_d = bit_cnt_q;
    settle_d  = settle_q;
`ifdef KEY_PARITY_EN
    err_d     = err_q;
`endif
    if (bus.abort) begin
      state_d   = IDLE;
      key_d     = '0;
      bit_cnt_d = '0;
      settle_d  = '0;
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (bus.start) begin
            state_d   = SHIFT;
            shadow_d  = '0;
            bit_cnt_d = '0;
`ifdef KEY_PARITY_EN
            err_d     = 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (bus.key_sv) begin
            shadow_d  = {shadow_q[KEY_W-2:0], bus.key_sdi};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (last_bit) begin
`ifdef KEY_PARITY_EN
              state_d  = CHECK;
`else
              state_d  = SETTLE;
              key_d    = {shadow_q[KEY_W-2:0], bus.key_sdi};
              settle_d = 8'(SETTLE_CYC);
`endif
            end
          end
        end
`ifdef KEY_PARITY_EN
        CHECK: begin
          if (bus.key_sv) begin
            if (parity_ok) begin
              state_d  = SETTLE;
              key_d    = shadow_q;
              settle_d = 8'(SETTLE_CYC);
            end else begin
              state_d  = IDLE;
              key_d    = '0;
              err_d    = 1'b1;
            end
          end
        end
`endif
        SETTLE: begin
          if (settle_q == 8'd0) begin
            state_d = READY;
          end else begin
            settle_d = settle_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      key_q     <= '0;
      bit_cnt_q <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      key_q     <= key_d;
      bit_cnt_q <= bit_cnt_d;
      settle_q  <= settle_d;
    end
  end

`ifdef KEY_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.keyinput  = key_q;
  assign bus.key_ready = (state_q == READY);
`ifdef KEY_PARITY_EN
  assign bus.busy      = (state_q == SHIFT) || (state_q == CHECK) || (state_q == SETTLE);
`else
  assign bus.busy      = (state_q == SHIFT) || (state_q == SETTLE);
`endif
  assign bus.core_out  = bus.key_ready ? bus.core_in : 7'h00;
endmodule
